// File: rtl/dbus_master.sv
// dbus_master -- peripheral data bus initiator.
//
// Accepts read/write commands on a valid/ready port, queues them in a small
// FIFO and issues them one at a time on the type_dbus2peri_s request channel.
// Every request field is held stable from the pop edge until ack. A missing
// ack is turned into an error response after TIMEOUT_CYCLES cycles, so a bad
// address never blocks the command source.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   cmd_valid_i/_ready_o, cmd_we_i, cmd_addr_i, cmd_wdata_i   command port
//   rsp_valid_o/ready_i, rsp_rdata_o, rsp_we_o, rsp_err_o      response port
//   dbus2peri_o        request channel (addr, w_data, w_en, req; rest 0)
//   peri2dbus_i        response channel (ack, r_data)
//   busy_o             FIFO non-empty or a transaction in progress

package dbus_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] w_data;
    logic        w_en;
    logic [3:0]  id;
    logic        req;
  } type_dbus2peri_s;

  typedef struct packed {
    logic [31:0] r_data;
    logic        ack;
  } type_peri2dbus_s;
endpackage

module dbus_master
  import dbus_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic            cmd_we_i,
  input  logic [31:0]     cmd_addr_i,
  input  logic [31:0]     cmd_wdata_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [31:0]     rsp_rdata_o,
  output logic            rsp_we_o,
  output logic            rsp_err_o,
  output type_dbus2peri_s dbus2peri_o,
  input  type_peri2dbus_s peri2dbus_i,
  output logic            busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [AW:0]   FIFO_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] TMO_ONE   = CW'(1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_e;

  // ---------------------------------------------------------------- FIFO
  cmd_t          mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push, pop;
  cmd_t          head;

  assign cmd_ready_o = (cnt_q != FIFO_FULL);
  assign push        = cmd_valid_i & cmd_ready_o;
  assign head        = mem_q[rd_ptr_q];

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{we: cmd_we_i, addr: cmd_addr_i, wdata: cmd_wdata_i};
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      cnt_q <= cnt_d;
    end
  end

  // ---------------------------------------------------------------- FSM
  state_e        state_q, state_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_we_q, rsp_we_d;
  logic          rsp_err_q, rsp_err_d;
  logic          busy_q, busy_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      tmo_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_we_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      tmo_q       <= tmo_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_we_q    <= rsp_we_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    tmo_d       = tmo_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_we_d    = rsp_we_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        // Head is only visible once it has been written on an earlier edge,
        // so a command never bypasses the FIFO.
        if (cnt_q != '0) begin
          pop     = 1'b1;
          we_d    = head.we;
          addr_d  = head.addr;
          wdata_d = head.wdata;
          req_d   = 1'b1;
          tmo_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // ack wins over the timeout when both land on the same edge.
        if (peri2dbus_i.ack) begin
          req_d       = 1'b0;
          rsp_rdata_d = we_q ? 32'h0 : peri2dbus_i.r_data;
          rsp_we_d    = we_q;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else if (tmo_q == TMO_LAST) begin
          req_d       = 1'b0;
          rsp_rdata_d = 32'h0;
          rsp_we_d    = we_q;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_d = (cnt_d != '0) || (state_d != S_IDLE);

  // ---------------------------------------------------------------- outputs
  always_comb begin
    dbus2peri_o        = '0;
    dbus2peri_o.addr   = addr_q;
    dbus2peri_o.w_data = wdata_q;
    dbus2peri_o.w_en   = we_q & req_q;
    dbus2peri_o.req    = req_q;
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_we_o    = rsp_we_q;
  assign rsp_err_o   = rsp_err_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_dbus_master.sv
// Directed plus randomized bench for dbus_master with a responder model that
// acks mapped addresses (< 0x1000) after a programmable delay and never acks
// anything else. Expected responses come from a command-order queue.
module tb_dbus_master;
  import dbus_pkg::*;

  localparam int TMO = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cmd_valid_i = 1'b0, cmd_ready_o, cmd_we_i = 1'b0;
  logic [31:0]     cmd_addr_i = '0, cmd_wdata_i = '0;
  logic            rsp_valid_o, rsp_ready_i = 1'b1;
  logic [31:0]     rsp_rdata_o;
  logic            rsp_we_o, rsp_err_o, busy_o;
  type_dbus2peri_s d2p;
  type_peri2dbus_s p2d;

  always #5 clk = ~clk;

  dbus_master #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_we_o(rsp_we_o), .rsp_err_o(rsp_err_o),
    .dbus2peri_o(d2p), .peri2dbus_i(p2d), .busy_o(busy_o)
  );

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_005A;
  endfunction

  // ---------------------------------------------------------- responder
  logic        ack = 1'b0;
  logic [31:0] rdat = '0;
  logic        resp_en = 1'b1, force_ack = 1'b0, rnd_dly = 1'b0, rnd_ready = 1'b0;
  int unsigned dly = 0, wcnt = 0;

  assign p2d.ack    = ack;
  assign p2d.r_data = rdat;

  always @(posedge clk) begin
    if (rst) begin
      ack  <= 1'b0;
      wcnt <= 0;
    end else if (force_ack) begin
      ack <= 1'b1;
    end else if (ack) begin
      ack  <= 1'b0;
      rdat <= $urandom;
      dly  <= rnd_dly ? $urandom_range(0, 3) : 0;
    end else if (d2p.req && resp_en && d2p.addr < 32'h1000) begin
      if (wcnt >= dly) begin
        ack  <= 1'b1;
        rdat <= rd_fn(d2p.addr);
        wcnt <= 0;
      end else wcnt <= wcnt + 1;
    end else wcnt <= 0;
  end

  // ---------------------------------------------------------- monitor
  typedef struct {logic we; logic [31:0] rdata; logic err;} rsp_t;
  typedef struct {logic we; logic [31:0] addr; logic [31:0] wd;} bus_t;

  rsp_t obs_rsp [512];
  bus_t obs_bus [512];
  int   obs_rsp_n = 0, obs_bus_n = 0;
  int   stab_err = 0, other_err = 0, gap_err = 0, run = 0, last_run = 0, low_run = 99;
  logic        prev_req = 1'b0, prev_wen = 1'b0;
  logic [31:0] prev_addr = '0, prev_wd = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_req = 1'b0; run = 0; low_run = 99;
    end else begin
      if (d2p.id != '0) other_err++;
      if (d2p.req && prev_req &&
          (d2p.addr != prev_addr || d2p.w_data != prev_wd || d2p.w_en != prev_wen)) stab_err++;
      if (d2p.req) begin
        if (!prev_req && low_run < 2) gap_err++;
        run++; low_run = 0;
      end else begin
        if (prev_req) begin last_run = run; run = 0; end
        low_run++;
      end
      if (d2p.req && ack && obs_bus_n < 512) begin
        obs_bus[obs_bus_n] = '{d2p.w_en, d2p.addr, d2p.w_data};
        obs_bus_n++;
      end
      if (rsp_valid_o && rsp_ready_i && obs_rsp_n < 512) begin
        obs_rsp[obs_rsp_n] = '{rsp_we_o, rsp_rdata_o, rsp_err_o};
        obs_rsp_n++;
      end
      prev_req = d2p.req; prev_addr = d2p.addr; prev_wd = d2p.w_data; prev_wen = d2p.w_en;
    end
  end

  // ---------------------------------------------------------- model + checks
  rsp_t exp_q[$];
  bus_t bus_q[$];
  int   n_chk = 0, n_fail = 0, rsp_rd = 0, bus_rd = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drain();
    rsp_t o, e;
    bus_t ob, eb;
    while (rsp_rd < obs_rsp_n) begin
      o = obs_rsp[rsp_rd]; rsp_rd++;
      n_chk++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL rsp_unexpected: observed response %0d expected none", rsp_rd);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rsp_we", o.we, e.we);
        chk("rsp_rdata", o.rdata, e.rdata);
        chk("rsp_err", o.err, e.err);
      end
    end
    while (bus_rd < obs_bus_n) begin
      ob = obs_bus[bus_rd]; bus_rd++;
      n_chk++;
      assert (bus_q.size() != 0) else begin
        n_fail++;
        $error("FAIL bus_unexpected: observed acked request %0d expected none", bus_rd);
      end
      if (bus_q.size() != 0) begin
        eb = bus_q.pop_front();
        chk("bus_addr", ob.addr, eb.addr);
        chk("bus_w_en", ob.we, eb.we);
        if (eb.we) chk("bus_w_data", ob.wd, eb.wd);
      end
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    if (rnd_ready) rsp_ready_i = ($urandom_range(0, 3) != 0);
    drain();
  endtask

  task automatic push(input logic we, input logic [31:0] a, input logic [31:0] wd);
    int n = 0;
    logic mapped;
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_addr_i = a; cmd_wdata_i = wd;
    while (!cmd_ready_o && n < 100) begin step(); n++; end
    chk("push_ready", cmd_ready_o, 1);
    step();
    cmd_valid_i = 1'b0;
    mapped = (a < 32'h1000);
    exp_q.push_back('{we, (we || !mapped) ? 32'h0 : rd_fn(a), !mapped});
    if (mapped) bus_q.push_back('{we, a, wd});
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!rsp_valid_o && n < 40) begin step(); n++; end
    chk(tag, rsp_valid_o, 1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || bus_q.size() != 0 || busy_o) && n < budget) begin step(); n++; end
    chk(tag, (exp_q.size() == 0 && bus_q.size() == 0 && !busy_o), 1);
  endtask

  initial begin
    logic [31:0] a[6], w[6], snap_rd;
    logic        we6[6];
    logic [1:0]  snap_we_err;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_d2p", {31'b0, |d2p}, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_rdata", rsp_rdata_o, 0);
    chk("rst_rsp_err", rsp_err_o, 0);
    chk("rst_rsp_we", rsp_we_o, 0);
    chk("rst_busy", busy_o, 0);
    rst = 1'b0;
    step();
    chk("rst_cmd_ready", cmd_ready_o, 1);

    // write 0xF0 to 0x04, one-cycle-ack responder, exact latency
    push(1'b1, 32'h4, 32'hF0);
    chk("t1_req_e0", d2p.req, 0);
    chk("t1_busy_e0", busy_o, 1);
    step();
    chk("t1_req_e1", d2p.req, 1);
    chk("t1_wen_e1", d2p.w_en, 1);
    chk("t1_addr_e1", d2p.addr, 32'h4);
    chk("t1_wdata_e1", d2p.w_data, 32'hF0);
    step();
    chk("t1_req_e2", d2p.req, 1);
    chk("t1_valid_e2", rsp_valid_o, 0);
    step();
    chk("t1_valid_e3", rsp_valid_o, 1);
    chk("t1_req_e3", d2p.req, 0);
    chk("t1_we_e3", rsp_we_o, 1);
    chk("t1_err_e3", rsp_err_o, 0);
    chk("t1_rdata_e3", rsp_rdata_o, 0);
    wait_idle("t1_idle", 20);

    // read addr 0: r_data changing after ack must not move the response
    rsp_ready_i = 1'b0;
    push(1'b0, 32'h0, $urandom);
    wait_rsp("t2_rsp");
    chk("t2_rdata", rsp_rdata_o, 32'h5A);
    chk("t2_err", rsp_err_o, 0);
    step(); step();
    chk("t2_rdata_hold", rsp_rdata_o, 32'h5A);
    rsp_ready_i = 1'b1;
    wait_idle("t2_idle", 20);

    // unmapped read times out after exactly TMO cycles; late acks ignored
    rsp_ready_i = 1'b0;
    push(1'b0, 32'h0000_2000, 32'h0);
    wait_rsp("t3_rsp");
    step();
    chk("t3_req_cycles", last_run, TMO);
    chk("t3_err", rsp_err_o, 1);
    chk("t3_rdata", rsp_rdata_o, 0);
    force_ack = 1'b1; step(); force_ack = 1'b0; step();
    chk("t3_late_valid", rsp_valid_o, 1);
    chk("t3_late_err", rsp_err_o, 1);
    chk("t3_late_rdata", rsp_rdata_o, 0);
    chk("t3_late_req", d2p.req, 0);
    rsp_ready_i = 1'b1;
    wait_idle("t3_idle", 20);
    force_ack = 1'b1; step(); force_ack = 1'b0; step(); step();
    chk("t3_idle_ack_valid", rsp_valid_o, 0);
    chk("t3_idle_ack_busy", busy_o, 0);
    chk("t3_idle_ack_req", d2p.req, 0);

    // six commands against a stalled responder
    resp_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      we6[i] = 1'($urandom_range(0, 1));
      a[i]   = 32'($urandom_range(0, 1023)) << 2;
      w[i]   = $urandom;
    end
    for (int i = 0; i < 5; i++) push(we6[i], a[i], w[i]);
    chk("t4_full_ready", cmd_ready_o, 0);
    chk("t4_full_req", d2p.req, 1);
    cmd_valid_i = 1'b1; cmd_we_i = we6[5]; cmd_addr_i = a[5]; cmd_wdata_i = w[5];
    step();
    chk("t4_still_full", cmd_ready_o, 0);
    resp_en = 1'b1;
    push(we6[5], a[5], w[5]);
    wait_idle("t4_idle", 200);

    // response back-pressure holds outputs and blocks the next request
    rsp_ready_i = 1'b0;
    a[0] = 32'($urandom_range(0, 1023)) << 2;
    a[1] = 32'($urandom_range(0, 1023)) << 2;
    w[1] = $urandom;
    push(1'b0, a[0], 32'h0);
    push(1'b1, a[1], w[1]);
    wait_rsp("t5_rsp");
    snap_rd = rsp_rdata_o;
    snap_we_err = {rsp_we_o, rsp_err_o};
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_hold_valid", rsp_valid_o, 1);
      chk("t5_hold_rdata", rsp_rdata_o, snap_rd);
      chk("t5_hold_we_err", {30'b0, rsp_we_o, rsp_err_o}, {30'b0, snap_we_err});
      chk("t5_hold_req", d2p.req, 0);
    end
    rsp_ready_i = 1'b1;
    step();
    chk("t5_hs_valid", rsp_valid_o, 0);
    chk("t5_hs_req", d2p.req, 0);
    step();
    chk("t5_next_req", d2p.req, 1);
    chk("t5_next_addr", d2p.addr, a[1]);
    wait_idle("t5_idle", 30);

    // reset while req is high with two commands queued
    resp_en = 1'b0;
    for (int i = 0; i < 3; i++) push(1'b0, 32'($urandom_range(0, 1023)) << 2, 32'h0);
    chk("t6_req_before", d2p.req, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_d2p", {31'b0, |d2p}, 0);
    chk("t6_rst_valid", rsp_valid_o, 0);
    chk("t6_rst_busy", busy_o, 0);
    exp_q.delete();
    bus_q.delete();
    step(); step();
    rst = 1'b0;
    resp_en = 1'b1;
    step();
    chk("t6_post_ready", cmd_ready_o, 1);
    chk("t6_post_busy", busy_o, 0);
    push(1'b0, 32'h0000_0010, 32'h0);
    wait_idle("t6_idle", 30);

    // randomized traffic
    rnd_ready = 1'b1;
    rnd_dly   = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra;
      if ($urandom_range(0, 7) == 0) ra = 32'h0001_0000 | ($urandom & 32'h0000_FFFC);
      else ra = 32'($urandom_range(0, 1023)) << 2;
      push(1'($urandom_range(0, 1)), ra, $urandom);
      if ($urandom_range(0, 3) == 0) step();
    end
    rnd_ready = 1'b0;
    rsp_ready_i = 1'b1;
    wait_idle("rnd_idle", 2000);

    chk("req_stable", stab_err, 0);
    chk("other_fields_zero", other_err, 0);
    chk("req_gap", gap_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
